// File: rtl/ibex_rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rf_wport_arbiter
// Brief    : Shares the register-file write port between EX writeback and LSU
//            load writeback. Provides a one-entry LSU holding buffer with an
//            anti-starvation limit, and zero-sweeps x1..xN-1 after reset
//            because the latch array itself has no reset.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_rf_wport_arbiter #(
  parameter bit          RV32E        = 1'b0,
  parameter int unsigned DataWidth    = 32,
  parameter bit          INIT_CLEAR   = 1'b1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_addr_i,
  input  logic [DataWidth-1:0] ex_data_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_data_i,
  output logic                 lsu_ready_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 init_done_o,
  output logic                 pend_valid_o,
  output logic [4:0]           pend_addr_o,
  output logic [DataWidth-1:0] pend_data_o
);

  localparam int unsigned ADDR_WIDTH = RV32E ? 4 : 5;
  localparam int unsigned NUM_WORDS  = 2 ** ADDR_WIDTH;

  // Addresses are kept 5 bits wide and masked, so unused upper bits read 0.
  localparam logic [4:0] c_addr_mask    = 5'(NUM_WORDS - 1);
  localparam logic [4:0] c_last_addr    = 5'(NUM_WORDS - 1);
  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e c_reset_state = INIT_CLEAR ? ST_CLEAR : ST_RUN;

  state_e               r_state;
  state_e               w_state_next;
  logic [4:0]           r_sweep_addr;
  logic                 r_buf_valid;
  logic [4:0]           r_buf_addr;
  logic [DataWidth-1:0] r_buf_data;
  logic [3:0]           r_starve_cnt;

  logic [4:0] w_ex_addr;
  logic [4:0] w_lsu_addr;
  logic       w_run;
  logic       w_starved;
  logic       w_ex_fire;
  logic       w_lsu_fire;
  logic       w_buf_load;
  logic       w_buf_drain;
  logic       w_buf_cancel;

  assign w_ex_addr  = ex_addr_i & c_addr_mask;
  assign w_lsu_addr = lsu_addr_i & c_addr_mask;
  assign w_run      = (r_state == ST_RUN);

  // Starvation only exists while something sits in the buffer.
  assign w_starved   = r_buf_valid && (r_starve_cnt == c_starve_limit);
  assign lsu_ready_o = w_run && !r_buf_valid;
  assign ex_ready_o  = w_run && !w_starved;
  assign w_ex_fire   = ex_valid_i && ex_ready_o;
  assign w_lsu_fire  = lsu_valid_i && lsu_ready_o;

  // A newer EX write to the buffered register makes the buffered load stale.
  assign w_buf_cancel = w_ex_fire && r_buf_valid && (w_ex_addr == r_buf_addr);

  assign init_done_o  = w_run;
  assign pend_valid_o = r_buf_valid;
  assign pend_addr_o  = r_buf_addr;
  assign pend_data_o  = r_buf_data;

  // Next-state and write-port selection: sweep in CLEAR, fixed priority in RUN.
  always_comb begin
    w_state_next = r_state;
    rf_we_o      = 1'b0;
    rf_waddr_o   = 5'd0;
    rf_wdata_o   = '0;
    w_buf_load   = 1'b0;
    w_buf_drain  = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = r_sweep_addr;
        if (r_sweep_addr == c_last_addr) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_starved) begin
          rf_we_o     = 1'b1;
          rf_waddr_o  = r_buf_addr;
          rf_wdata_o  = r_buf_data;
          w_buf_drain = 1'b1;
        end else if (ex_valid_i) begin
          rf_we_o    = (w_ex_addr != 5'd0);
          rf_waddr_o = w_ex_addr;
          rf_wdata_o = ex_data_i;
          // A colliding load is parked rather than dropped; x0 loads vanish.
          w_buf_load = w_lsu_fire && (w_lsu_addr != 5'd0);
        end else if (r_buf_valid) begin
          rf_we_o     = 1'b1;
          rf_waddr_o  = r_buf_addr;
          rf_wdata_o  = r_buf_data;
          w_buf_drain = 1'b1;
        end else if (w_lsu_fire) begin
          rf_we_o    = (w_lsu_addr != 5'd0);
          rf_waddr_o = w_lsu_addr;
          rf_wdata_o = lsu_data_i;
        end
      end
      default: begin
        w_state_next = c_reset_state;
      end
    endcase
  end

  // State register and post-reset sweep address.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= c_reset_state;
      r_sweep_addr <= 5'd1;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_CLEAR) begin
        r_sweep_addr <= (r_sweep_addr + 5'd1) & c_addr_mask;
      end
    end
  end

  // LSU holding buffer: load on collision, clear on drain or cancellation.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf_valid <= 1'b0;
      r_buf_addr  <= 5'd0;
      r_buf_data  <= '0;
    end else if (w_buf_load) begin
      r_buf_valid <= 1'b1;
      r_buf_addr  <= w_lsu_addr;
      r_buf_data  <= lsu_data_i;
    end else if (w_buf_drain || w_buf_cancel) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Counts cycles the buffered entry is passed over; saturates at the limit.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve_cnt <= 4'd0;
    end else if (r_buf_valid && !w_buf_drain && !w_buf_cancel) begin
      if (r_starve_cnt != c_starve_limit) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

endmodule
`default_nettype wire
